// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one MOV/RW/MOC memory port between instruction fetch
// and data requesters; holds the access until MOC or timeout, then pulses the matching ack.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [1:0]    d_size,
    input  logic          MOC,
    input  logic [DW-1:0] mem_rdata,
    output logic          MOV,
    output logic          RW,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_size,
    output logic          if_ack,
    output logic          d_ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy
);

    // state  | meaning
    // IDLE   | no access in flight, arbitrate between requesters
    // ACCESS | MOV high, address/data/size/RW held, waiting for MOC or timeout
    // RESP   | one-cycle ack pulse to the granted requester
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t          state_q;
    logic            mov_q;
    logic            rw_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [1:0]      size_q;
    logic            if_ack_q;
    logic            d_ack_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;
    logic            busy_q;
    logic            last_d_q;
    logic            gnt_d_q;
    logic [CW-1:0]   cnt_q;

    logic            req_any_d;
    logic            pick_d_d;
    logic            timeout_hit_d;

    // Contested grants go to whichever side was not served last.
    always_comb begin
        req_any_d     = if_req | d_req;
        pick_d_d      = d_req & (~if_req | ~last_d_q);
        timeout_hit_d = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mov_q    <= 1'b0;
            rw_q     <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= SIZE_WORD;
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            last_d_q <= 1'b1;
            gnt_d_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    if (req_any_d) begin
                        state_q  <= ST_ACCESS;
                        mov_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        gnt_d_q  <= pick_d_d;
                        last_d_q <= pick_d_d;
                        if (pick_d_d) begin
                            rw_q    <= d_rw;
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                            size_q  <= d_size;
                        end else begin
                            // Fetches are always word reads; store data is left as-is.
                            rw_q    <= 1'b1;
                            addr_q  <= if_addr;
                            size_q  <= SIZE_WORD;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (MOC || timeout_hit_d) begin
                        state_q  <= ST_RESP;
                        mov_q    <= 1'b0;
                        if_ack_q <= ~gnt_d_q;
                        d_ack_q  <= gnt_d_q;
                        err_q    <= ~MOC;
                        if (MOC && rw_q) begin
                            rdata_q <= mem_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    state_q  <= ST_IDLE;
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mov_q    <= 1'b0;
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign MOV       = mov_q;
    assign RW        = rw_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule
